// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_loader.
// slave : the loader (consumes the stream, drives the memory write port).
// master: the stream source / memory side.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes little-endian
// 32-bit words into instruction memory at consecutive word addresses, holding
// the core in reset while loading.
// Stream format: len[7:0], len[15:8] (word count), then 4*len data bytes.
// Optional macro IMEM_LOADER_CHECKSUM_EN appends one checksum byte (XOR of the
// length and data bytes); a mismatch sets err until the next start or reset.
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | waiting for start, core released from reset
// LEN_LO  | accepting low byte of the word count
// LEN_HI  | accepting high byte of the word count
// DATA    | accepting the four bytes of the current word
// WRITE   | one-cycle memory write of the assembled word
// CSUM    | accepting the checksum byte (checksum build only)
// DONE    | one-cycle completion pulse
module imem_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          cpu_rst,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM   = 3'd5,
`endif
        S_DONE   = 3'd6
    } state_t;

    // State entered once the last word is written (or for an empty load).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state, state_next;
    logic              ready;
    logic              xfer;
    logic [ADDR_W-1:0] index;
    logic [1:0]        byte_cnt;
    logic [15:0]       remaining;
    logic [7:0]        len_lo;
    logic [31:0]       asm_word;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              cpu_rst_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xsum;
    logic              err_q;
`endif

    assign xfer = bus.in_valid && ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LEN_LO;
            S_LEN_LO: if (xfer)  state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    if ({bus.in_data, len_lo} == 16'd0) state_next = S_TAIL;
                    else                                state_next = S_DATA;
                end
            end
            S_DATA:   if (xfer && byte_cnt == 2'd3) state_next = S_WRITE;
            S_WRITE: begin
                if (remaining == 16'd1) state_next = S_TAIL;
                else                    state_next = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:   if (xfer) state_next = S_DONE;
`endif
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        ready  = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (state)
            S_IDLE:   busy  = 1'b0;
            S_LEN_LO: ready = 1'b1;
            S_LEN_HI: ready = 1'b1;
            S_DATA:   ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:   ready = 1'b1;
`endif
            S_DONE:   done  = 1'b1;
            default:  ;
        endcase
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_rst       = cpu_rst_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

    // Datapath: length capture, word assembly, write address/data, core reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index     <= '0;
            byte_cnt  <= 2'd0;
            remaining <= 16'd0;
            len_lo    <= 8'd0;
            asm_word  <= 32'd0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= 32'd0;
            cpu_rst_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum      <= 8'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            // Core leaves reset only once the loader is back in IDLE.
            cpu_rst_q <= (state_next == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        index    <= '0;
                        byte_cnt <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum     <= 8'd0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= bus.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum   <= xsum ^ bus.in_data;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        remaining <= {bus.in_data, len_lo};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum      <= xsum ^ bus.in_data;
`endif
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        asm_word[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum     <= xsum ^ bus.in_data;
`endif
                        // Latch the write port on the last byte so it is
                        // stable for the whole WRITE cycle and after.
                        if (byte_cnt == 2'd3) begin
                            wdata_q <= {bus.in_data, asm_word[23:0]};
                            addr_q  <= BASE_ADDR + (32'(index) << 2);
                        end
                    end
                end
                S_WRITE: begin
                    index     <= index + 1'b1;
                    remaining <= remaining - 16'd1;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) err_q <= (xsum != bus.in_data);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (ADDR_W=10 and ADDR_W=2) share one
// stimulus stream; expected write logs come from a word-level stream model.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if bus0 ();
    imem_loader_if bus1 ();

    assign bus0.in_data  = in_data;
    assign bus0.in_valid = in_valid;
    assign bus1.in_data  = in_data;
    assign bus1.in_valid = in_valid;

    logic busy0, done0, cpu0, err0;
    logic busy1, done1, cpu1, err1;

    imem_loader #(.ADDR_W(10), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .bus(bus0.slave),
        .busy(busy0), .done(done0), .cpu_rst(cpu0), .err(err0)
    );

    imem_loader #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .bus(bus1.slave),
        .busy(busy1), .done(done1), .cpu_rst(cpu1), .err(err1)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] got0[$], got1[$], exp0[$], exp1[$];
    int          done_cnt = 0;
    int          busy_cyc = 0;
    bit          exp_err  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: write logs, done/busy counting, invariants.
    always @(negedge clk) begin
        if (bus0.mem_we) got0.push_back({bus0.mem_addr, bus0.mem_wdata});
        if (bus1.mem_we) got1.push_back({bus1.mem_addr, bus1.mem_wdata});
        if (bus0.mem_we) chk("in_ready_during_write", 64'(bus0.in_ready), 64'(0));
        if (busy0)       chk("cpu_rst_while_busy", 64'(cpu0), 64'(0));
        if (done0) done_cnt++;
        if (busy0) busy_cyc++;
        chk("instances_lockstep",
            64'({bus1.in_ready, bus1.mem_we, busy1, done1, cpu1, err1}),
            64'({bus0.in_ready, bus0.mem_we, busy0, done0, cpu0, err0}));
    end

    // Called at a negedge; returns at a negedge after the byte has transferred.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n = 0;
        while (1) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
            end
            if (in_valid && bus0.in_ready) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
                in_data = 8'h00;
                @(negedge clk);
                return;
            end
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("handshake_timeout", 64'(0), 64'(1));
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    // Builds the expected write log for a load of nwords words.
    task automatic build_model(input int nwords, input logic [7:0] data[$]);
        exp0.delete();
        exp1.delete();
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] word;
            word = {data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]};
            exp0.push_back({32'((w % 1024) * 4), word});
            exp1.push_back({32'((w % 4) * 4), word});
        end
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_count_a10"}, 64'(got0.size()), 64'(exp0.size()));
        chk({tag, "_count_a2"},  64'(got1.size()), 64'(exp1.size()));
        for (int i = 0; i < exp0.size(); i++)
            if (i < got0.size()) chk({tag, "_write_a10"}, got0[i], exp0[i]);
        for (int i = 0; i < exp1.size(); i++)
            if (i < got1.size()) chk({tag, "_write_a2"}, got1[i], exp1[i]);
    endtask

    // csum_sel < 0 sends the correct checksum, otherwise the given byte.
    task automatic run_load(input string tag, input int nwords, input logic [7:0] data[$],
                            input bit rnd, input int csum_sel, input bit start_noise);
        logic [7:0] s[$];
        logic [7:0] x;
        logic [7:0] cs;
        int         n;
        s.push_back(nwords[7:0]);
        s.push_back(nwords[15:8]);
        foreach (data[i]) s.push_back(data[i]);
        x = 8'h00;
        foreach (s[i]) x = x ^ s[i];
        build_model(nwords, data);
        exp_err = 1'b0;
        got0.delete();
        got1.delete();
        done_cnt = 0;
        busy_cyc = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (s[i]) begin
            if (start_noise) start = 1'($urandom_range(0, 1));
            send_byte(s[i], rnd);
        end
        start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cs = (csum_sel < 0) ? x : csum_sel[7:0];
        exp_err = (cs != x);
        send_byte(cs, rnd);
`else
        cs = 8'h00;
`endif
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt > 0), 64'(1));
        @(negedge clk);
        chk({tag, "_done_once"}, 64'(done_cnt), 64'(1));
        chk({tag, "_busy_low"},  64'(busy0), 64'(0));
        chk({tag, "_cpu_rst"},   64'(cpu0), 64'(1));
        chk({tag, "_err"},       64'(err0), 64'(exp_err));
        compare_logs(tag);
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] empty_q[$];

        // Reset state.
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready",  64'(bus0.in_ready),  64'(0));
        chk("rst_mem_we",    64'(bus0.mem_we),    64'(0));
        chk("rst_mem_addr",  64'(bus0.mem_addr),  64'(32'h0));
        chk("rst_mem_wdata", 64'(bus0.mem_wdata), 64'(32'h0));
        chk("rst_busy",      64'(busy0),          64'(0));
        chk("rst_done",      64'(done0),          64'(0));
        chk("rst_cpu_rst",   64'(cpu0),           64'(0));
        chk("rst_err",       64'(err0),           64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("cpu_rst_after_release", 64'(cpu0), 64'(1));

        // Two-word program, no stalls.
        d = '{8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'h30, 8'h00};
        run_load("prog", 2, d, 1'b0, -1, 1'b0);
        chk("prog_word0", exp0[0], {32'h0, 32'h00500293});
        chk("prog_word1", exp0[1], {32'h4, 32'h00300313});

        // Same stream with random valid gaps and start held mid-load.
        run_load("prog_gaps", 2, d, 1'b1, -1, 1'b1);

        // Empty load.
        run_load("len0", 0, empty_q, 1'b0, -1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("len0_busy_cycles", 64'(busy_cyc), 64'(4));
`else
        chk("len0_busy_cycles", 64'(busy_cyc), 64'(3));
`endif

        // Five words: the ADDR_W=2 instance wraps to address 0.
        d.delete();
        for (int i = 0; i < 20; i++) d.push_back(8'($urandom));
        run_load("len5", 5, d, 1'b0, -1, 1'b0);
        chk("len5_wrap_addr", 64'(exp1[4][63:32]), 64'(32'h0));

        // Reset after two data bytes.
        got0.delete();
        got1.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready",  64'(bus0.in_ready),  64'(0));
        chk("midrst_mem_we",    64'(bus0.mem_we),    64'(0));
        chk("midrst_mem_addr",  64'(bus0.mem_addr),  64'(32'h0));
        chk("midrst_mem_wdata", 64'(bus0.mem_wdata), 64'(32'h0));
        chk("midrst_busy",      64'(busy0),          64'(0));
        chk("midrst_cpu_rst",   64'(cpu0),           64'(0));
        chk("midrst_err",       64'(err0),           64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_no_write", 64'(got0.size()), 64'(0));
        d = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};
        run_load("after_rst", 1, d, 1'b0, -1, 1'b0);

        // Checksum cases (err stays 0 without the checksum build).
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load("csum_ok", 1, d, 1'b0, 8'h45, 1'b0);
        run_load("csum_bad", 1, d, 1'b0, 8'h00, 1'b0);
        chk("csum_bad_word", exp0[0], {32'h0, 32'h44332211});

        // Randomized loads with random gaps.
        for (int t = 0; t < 5; t++) begin
            int nw;
            nw = int'($urandom_range(1, 7));
            d.delete();
            for (int i = 0; i < 4 * nw; i++) d.push_back(8'($urandom));
            run_load("rand", nw, d, 1'b1, (t == 2) ? 8'h5A : -1, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives the instruction-memory write port (we/addr/wdata) at consecutive word addresses.
- Holds the core in reset while loading; the core then fetches the loaded program through the normal read port.

Parameters:
- ADDR_W, 10, word-address width; 2^ADDR_W words (1024). Word index wraps modulo 2^ADDR_W.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  begin a load; sampled only in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address; word index placed on bits [ADDR_W+1:2], bits [1:0] = 0.
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a load completes.
- cpu_rst  output  1  active-low core reset; 0 while busy or in reset, 1 otherwise.
- err  output  1  checksum mismatch flag (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, cpu_rst=0, err=0, word index=0, byte count=0.
- Reset mid-load: all state cleared as above; the partial word is discarded and no write is issued.
- cpu_rst is registered: 0 in reset and in all busy states, 1 in IDLE after the first clock edge following reset release.
- Handshake: a byte transfers when in_valid && in_ready at a rising edge. in_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM; it is 0 in IDLE, WRITE and DONE.
- States and transitions:
  - IDLE: on start=1, go to LEN_LO; clear word index, byte count and err.
  - LEN_LO: transfer loads len[7:0]; go to LEN_HI.
  - LEN_HI: transfer loads len[15:8]. If the 16-bit len is 0, go to CSUM (with macro) or DONE (without). Otherwise go to DATA.
  - DATA: the k-th byte of a word (k=0..3) is stored in wdata[8k+7:8k]. After the 4th transfer, go to WRITE.
  - WRITE: mem_we=1 for exactly this cycle, with mem_addr = BASE_ADDR + 4*index and mem_wdata = the assembled word. Then increment index (wrapping at 2^ADDR_W) and decrement remaining length. If remaining is 0, go to CSUM or DONE; otherwise go to DATA.
  - DONE: done=1 for one cycle, then go to IDLE.
- Latency: mem_we rises in the cycle after the 4th byte's handshake. Maximum throughput is 4 bytes per 5 cycles.
- start while busy: ignored.
- start and in_valid together in IDLE: no byte is consumed that cycle.
- len > 2^ADDR_W: addresses wrap and earlier words are overwritten. This is not an error.
- mem_addr and mem_wdata hold their values outside WRITE; only mem_we qualifies them.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - The CSUM state follows the last word (or LEN_HI when len=0) and accepts one byte.
  - The running XOR covers all length and data bytes. err is set if that XOR differs from the CSUM byte.
  - err holds its value until the next start or reset.
  - CSUM then goes to DONE.
  - Words already written are not rolled back.
- Without the macro: no CSUM state, and err is tied to 0.

Test Plan:
- Reset then start; stream 02 00, 93 02 50 00, 13 03 30 00 → mem_we pulses twice: addr 0x0 with wdata 0x00500293, then addr 0x4 with 0x00300313. done pulses once; cpu_rst is 0 during the load and 1 after.
- in_valid toggled randomly during the same stream → identical writes; no byte lost or duplicated; in_ready=0 during the WRITE cycles.
- len=0 (bytes 00 00) → no mem_we; done pulses; busy lasts exactly 3 cycles (LEN_LO, LEN_HI, DONE) without the macro.
- ADDR_W=2, len=5 → writes to addrs 0x0, 0x4, 0x8, 0xC, then 0x0 again (wrap).
- rst=0 asserted after 2 of 4 data bytes → all outputs at reset values immediately. A following load of 1 word writes addr 0x0 with only the new bytes.
- With IMEM_LOADER_CHECKSUM_EN: stream 01 00 11 22 33 44 plus checksum 0x45 → err=0. The same stream with checksum 0x00 → err=1, and the word 0x44332211 is still written.
